// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one alu32 among NREQ requesters

// Single-cycle 32-bit ALU; Z flags an all-zero result.
module alu32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUC,
    output logic [31:0] RES,
    output logic        Z
);

    // Opcode decode; bit 3 only distinguishes arithmetic from logical right shift
    always_comb begin
        RES = '0;
        casez (ALUC)
            4'b?000: RES = A + B;
            4'b?100: RES = A - B;
            4'b?001: RES = A & B;
            4'b?101: RES = A | B;
            4'b?010: RES = A ^ B;
            4'b?110: RES = {B[15:0], 16'h0000};
            4'b?011: RES = B << A[4:0];
            4'b0111: RES = B >> A[4:0];
            4'b1111: RES = 32'($signed(B) >>> A[4:0]);
            default: RES = '0;
        endcase
        Z = (RES == 32'h0);
    end

endmodule

module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*32-1:0] REQ_A,
    input  logic [NREQ*32-1:0] REQ_B,
    input  logic [NREQ*4-1:0] REQ_ALUC,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RES,
    output logic              RSP_Z,
    output logic [IDW-1:0]    RSP_ID,
    output logic              BUSY
);

    localparam int SW = IDW + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_res_q, rsp_res_d;
    logic           rsp_z_q, rsp_z_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           gap_q;

    logic [SW-1:0]  scan_idx;
    logic [IDW-1:0] win;
    logic           any_valid;
    logic           slot_free;
    logic           grant_ok;

    logic [31:0]    alu_a, alu_b, alu_res;
    logic [3:0]     alu_c;
    logic           alu_z;

    // Round-robin scan starting at the pointer; the first valid requester wins
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + SW'(k);
            if (scan_idx >= SW'(NREQ)) begin
                scan_idx = scan_idx - SW'(NREQ);
            end
            if (!any_valid && REQ_VALID[scan_idx[IDW-1:0]]) begin
                any_valid = 1'b1;
                win       = scan_idx[IDW-1:0];
            end
        end
    end

    // Grant only when the response slot can take a result; the cycle right after
    // reset never grants, and the path is independent of the ALU output
    always_comb begin
        slot_free = !rsp_valid_q || RSP_READY;
        grant_ok  = any_valid && slot_free && !gap_q && !RST;
        REQ_READY = grant_ok ? (NREQ'(1) << win) : '0;
    end

    // Operand mux from the winner; zero when nobody is requesting
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (any_valid && (IDW'(k) == win)) begin
                alu_a = REQ_A[32*k +: 32];
                alu_b = REQ_B[32*k +: 32];
                alu_c = REQ_ALUC[4*k +: 4];
            end
        end
    end

    alu32 u_alu (
        .A    (alu_a),
        .B    (alu_b),
        .ALUC (alu_c),
        .RES  (alu_res),
        .Z    (alu_z)
    );

    // Response slot next state: load on grant, drain on consumer ready, else hold
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        if (grant_ok) begin
            rsp_valid_d = 1'b1;
            rsp_res_d   = alu_res;
            rsp_z_d     = alu_z;
            rsp_id_d    = win;
            ptr_d       = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
        end else if (rsp_valid_q && RSP_READY) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending response
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_z_q     <= 1'b0;
            rsp_id_q    <= '0;
            gap_q       <= 1'b1;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
            gap_q       <= 1'b0;
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_RES   = rsp_res_q;
    assign RSP_Z     = rsp_z_q;
    assign RSP_ID    = rsp_id_q;
    assign BUSY      = rsp_valid_q || (|REQ_VALID);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized bench for alu_share_arbiter against a behavioural model

module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     REQ_VALID;
    logic [NREQ-1:0]     REQ_READY;
    logic [NREQ*32-1:0]  REQ_A;
    logic [NREQ*32-1:0]  REQ_B;
    logic [NREQ*4-1:0]   REQ_ALUC;
    logic                RSP_VALID;
    logic                RSP_READY;
    logic [31:0]         RSP_RES;
    logic                RSP_Z;
    logic [IDW-1:0]      RSP_ID;
    logic                BUSY;

    always #5 CLK = ~CLK;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .REQ_ALUC  (REQ_ALUC),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RES   (RSP_RES),
        .RSP_Z     (RSP_Z),
        .RSP_ID    (RSP_ID),
        .BUSY      (BUSY)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // stimulus for the next cycle
    logic [31:0]     op_a [NREQ];
    logic [31:0]     op_b [NREQ];
    logic [3:0]      op_c [NREQ];
    logic [NREQ-1:0] tv;
    logic            trr;
    logic            trst;

    // reference model state
    bit          m_valid;
    logic [31:0] m_res;
    bit          m_z;
    int          m_id;
    int          m_ptr;
    bit          m_gap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a[4:0]);
        case (op[2:0])
            3'b000: return a + b;
            3'b100: return a - b;
            3'b001: return a & b;
            3'b101: return a | b;
            3'b010: return a ^ b;
            3'b110: return b * 32'h10000;
            3'b011: return b << sh;
            default: begin
                if (op[3]) return 32'($signed(b) >>> sh);
                return b >> sh;
            end
        endcase
    endfunction

    function automatic int pick_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (tv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic idle();
        tv   = '0;
        trr  = 1'b1;
        trst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
            op_c[k] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        tv[i]   = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
        op_c[i] = c;
    endtask

    // one clock: drive at negedge, check grant, advance model at posedge, check response
    task automatic cycle();
        int              w;
        bit              free;
        logic [NREQ-1:0] exp_rdy;
        @(negedge CLK);
        for (int k = 0; k < NREQ; k++) begin
            REQ_A[32*k +: 32]  = op_a[k];
            REQ_B[32*k +: 32]  = op_b[k];
            REQ_ALUC[4*k +: 4] = op_c[k];
        end
        REQ_VALID = tv;
        RSP_READY = trr;
        RST       = trst;
        #1;
        w       = pick_winner();
        free    = !m_valid || trr;
        exp_rdy = '0;
        if (!trst && !m_gap && free && w >= 0) exp_rdy[w] = 1'b1;
        check_eq("req_ready", 32'(REQ_READY), 32'(exp_rdy));
        check_eq("busy", 32'(BUSY), 32'(m_valid || (tv != '0)));
        @(posedge CLK);
        if (trst) begin
            m_valid = 0; m_res = '0; m_z = 0; m_id = 0; m_ptr = 0; m_gap = 1;
        end else begin
            m_gap = 0;
            if (exp_rdy != '0) begin
                m_res   = alu_ref(op_c[w], op_a[w], op_b[w]);
                m_z     = (m_res == 32'h0);
                m_id    = w;
                m_valid = 1;
                m_ptr   = (w + 1) % NREQ;
            end else if (m_valid && trr) begin
                m_valid = 0;
            end
        end
        #1;
        check_eq("rsp_valid", 32'(RSP_VALID), 32'(m_valid));
        check_eq("rsp_res", RSP_RES, m_res);
        check_eq("rsp_z", 32'(RSP_Z), 32'(m_z));
        check_eq("rsp_id", 32'(RSP_ID), 32'(m_id));
    endtask

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        idle();
        RST = 1'b1; REQ_VALID = '0; RSP_READY = 1'b1; REQ_A = '0; REQ_B = '0; REQ_ALUC = '0;
        repeat (2) @(posedge CLK);
        #1;
        m_valid = 0; m_res = '0; m_z = 0; m_id = 0; m_ptr = 0; m_gap = 1;
        check_eq("reset_valid", 32'(RSP_VALID), 32'd0);
        check_eq("reset_res", RSP_RES, 32'd0);
        check_eq("reset_z", 32'(RSP_Z), 32'd0);
        check_eq("reset_id", 32'(RSP_ID), 32'd0);

        // leave the post-reset no-grant cycle behind
        idle(); cycle();

        // single request, no contention
        idle(); set_req(2, 32'd5, 32'd7, 4'b0000); cycle();
        check_eq("single_res", RSP_RES, 32'd12);
        check_eq("single_id", 32'(RSP_ID), 32'd2);

        // subtract to zero; pointer at 3 wraps to requester 0
        idle(); set_req(0, 32'd9, 32'd9, 4'b0100); cycle();
        check_eq("sub_res", RSP_RES, 32'd0);
        check_eq("sub_z", 32'(RSP_Z), 32'd1);
        check_eq("sub_id", 32'(RSP_ID), 32'd0);

        // arithmetic and logical right shift, then left shift via 1011
        idle(); set_req(1, 32'd4, 32'h8000_0000, 4'b1111); cycle();
        check_eq("sra_res", RSP_RES, 32'hF800_0000);
        idle(); set_req(1, 32'd4, 32'h8000_0000, 4'b0111); cycle();
        check_eq("srl_res", RSP_RES, 32'h0800_0000);
        idle(); set_req(3, 32'd4, 32'h0000_0003, 4'b1011); cycle();
        check_eq("sll_res", RSP_RES, 32'h0000_0030);

        // contention from reset
        idle(); trst = 1'b1; cycle();
        idle();
        for (int k = 0; k < NREQ; k++) set_req(k, $urandom, $urandom, 4'($urandom));
        cycle();
        for (int n = 0; n < 5; n++) begin
            cycle();
            check_eq("rr_id", 32'(RSP_ID), 32'(exp_seq[n]));
            check_eq("rr_valid", 32'(RSP_VALID), 32'd1);
        end

        // backpressure with requesters 1 and 3 waiting
        idle(); trr = 1'b0;
        set_req(1, 32'd100, 32'd1, 4'b0000);
        set_req(3, 32'd300, 32'd3, 4'b0000);
        repeat (3) cycle();
        trr = 1'b1; cycle();
        check_eq("bp_next_id", 32'(RSP_ID), 32'd1);
        check_eq("bp_next_res", RSP_RES, 32'd101);

        // reset while a response is held
        trr = 1'b0; cycle();
        trst = 1'b1; cycle();
        check_eq("rst_mid_valid", 32'(RSP_VALID), 32'd0);
        check_eq("rst_mid_id", 32'(RSP_ID), 32'd0);
        trst = 1'b0; trr = 1'b1; cycle();
        cycle();
        check_eq("rst_first_grant", 32'(RSP_ID), 32'd1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            tv   = NREQ'($urandom);
            trr  = ($urandom_range(0, 3) != 0);
            trst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NREQ; k++) begin
                op_a[k] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                op_b[k] = ($urandom_range(0, 3) == 0) ? op_a[k] : $urandom;
                op_c[k] = 4'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
